caxi4interconnect_req_rr_arbiter: RTL and testbench

CAXI4INTERCONNECT_REQ_RR_ARBITER -- requirements
Module: caxi4interconnect_req_rr_arbiter

---
 rtl/caxi4interconnect_arb_pkg.sv | 20 ++
 rtl/caxi4interconnect_rr_pick.sv | 35 +++
 rtl/caxi4interconnect_req_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_caxi4interconnect_req_rr_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caxi4interconnect_arb_pkg.sv
// Shared types and helpers for the request round-robin arbiter.
package caxi4interconnect_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    // Ceiling log2, used for sizing counters at elaboration time.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/caxi4interconnect_rr_pick.sv
// Combinational rotate-priority search: the first set request at or above
// rr_ptr wins, wrapping from NUM_SLAVES-1 back to 0.
module caxi4interconnect_rr_pick #(
    parameter int NUM_SLAVES       = 8,
    parameter int NUM_SLAVES_WIDTH = 3
) (
    input  logic [NUM_SLAVES-1:0]       req_qual,
    input  logic [NUM_SLAVES_WIDTH-1:0] rr_ptr,
    output logic [NUM_SLAVES-1:0]       winner,
    output logic [NUM_SLAVES_WIDTH-1:0] winner_idx,
    output logic                        any_req
);

    // Walk the requests starting at rr_ptr; only the first hit is taken.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            int                        idx;
            logic [NUM_SLAVES_WIDTH-1:0] idx_w;
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_SLAVES) begin
                idx = idx - NUM_SLAVES;
            end
            idx_w = NUM_SLAVES_WIDTH'(idx);
            if (!any_req && req_qual[idx_w]) begin
                any_req       = 1'b1;
                winner[idx_w] = 1'b1;
                winner_idx    = idx_w;
            end
        end
    end

endmodule

// File: rtl/caxi4interconnect_req_rr_arbiter.sv
// Round-robin request arbiter with registered one-hot and encoded grant.
// A grant is held until XFER_DONE; one idle cycle always separates grants.
// Optional watchdog release enabled by CAXI4INTERCONNECT_ARB_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | no grant held, arbitrating REQ_QUAL every cycle
//   GRANTED | grant frozen until XFER_DONE (or watchdog expiry)
module caxi4interconnect_req_rr_arbiter
    import caxi4interconnect_arb_pkg::*;
#(
    parameter int NUM_SLAVES       = 8,
    parameter int NUM_SLAVES_WIDTH = 3,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_SLAVES-1:0]       REQ_QUAL,
    input  logic                        XFER_DONE,
    output logic [NUM_SLAVES-1:0]       GRANT,
    output logic [NUM_SLAVES_WIDTH-1:0] GRANT_ENC,
    output logic                        GRANT_VALID,
    output logic                        TIMEOUT_ERR
);

    arb_state_e                  state_q, state_d;
    logic [NUM_SLAVES-1:0]       grant_q, grant_d;
    logic [NUM_SLAVES_WIDTH-1:0] grant_enc_q, grant_enc_d;
    logic [NUM_SLAVES_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_SLAVES-1:0]       pick_winner;
    logic [NUM_SLAVES_WIDTH-1:0] pick_idx;
    logic                        pick_any;
    logic                        wd_fire;

    caxi4interconnect_rr_pick #(
        .NUM_SLAVES       (NUM_SLAVES),
        .NUM_SLAVES_WIDTH (NUM_SLAVES_WIDTH)
    ) u_pick (
        .req_qual   (REQ_QUAL),
        .rr_ptr     (rr_ptr_q),
        .winner     (pick_winner),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

`ifdef CAXI4INTERCONNECT_ARB_TIMEOUT_EN
    localparam int CNT_W = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             timeout_err_q;

    // XFER_DONE wins over an expiring watchdog in the same cycle.
    assign wd_fire = (state_q == GRANTED) && !XFER_DONE &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts GRANTED cycles; held at zero in IDLE so it is clear on entry.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= wd_fire;
            if (state_q == IDLE) begin
                wd_cnt_q <= '0;
            end else if (!XFER_DONE) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    assign TIMEOUT_ERR = timeout_err_q;
`else
    assign wd_fire     = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    // Next-state: arbitrate in IDLE, hold in GRANTED until released.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_enc_d = grant_enc_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANTED;
                    grant_d     = pick_winner;
                    grant_enc_d = pick_idx;
                end
            end
            GRANTED: begin
                if (XFER_DONE || wd_fire) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    grant_enc_d = '0;
                    rr_ptr_d    = (grant_enc_q == NUM_SLAVES_WIDTH'(NUM_SLAVES - 1)) ?
                                  '0 : grant_enc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_enc_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_enc_q <= grant_enc_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign GRANT       = grant_q;
    assign GRANT_ENC   = grant_enc_q;
    assign GRANT_VALID = (state_q == GRANTED);

endmodule

// File: tb/tb_caxi4interconnect_req_rr_arbiter.sv
// Self-checking bench for caxi4interconnect_req_rr_arbiter.
module tb_caxi4interconnect_req_rr_arbiter;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int TO = 16;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [N-1:0] REQ_QUAL;
    logic         XFER_DONE;
    logic [N-1:0] GRANT;
    logic [W-1:0] GRANT_ENC;
    logic         GRANT_VALID;
    logic         TIMEOUT_ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    always #5 ACLK = ~ACLK;

    caxi4interconnect_req_rr_arbiter #(
        .NUM_SLAVES       (N),
        .NUM_SLAVES_WIDTH (W),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .REQ_QUAL    (REQ_QUAL),
        .XFER_DONE   (XFER_DONE),
        .GRANT       (GRANT),
        .GRANT_ENC   (GRANT_ENC),
        .GRANT_VALID (GRANT_VALID),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (GRANT_VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        ARESET    = 1'b1;
        REQ_QUAL  = '0;
        XFER_DONE = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (GRANT !== '0) begin
            n_bad++;
            $display("FAIL reset_grant: got %b, want 0", GRANT);
        end
        n_cmp++;
        if (GRANT_ENC !== '0) begin
            n_bad++;
            $display("FAIL reset_enc: got %0d, want 0", GRANT_ENC);
        end
        n_cmp++;
        if (GRANT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b, want 0", GRANT_VALID);
        end
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_terr: got %b, want 0", TIMEOUT_ERR);
        end
    endtask

    task automatic test_basic();
        bit           ok;
        int           e;
        logic [N-1:0] oh;
        REQ_QUAL = 8'b0000_0101;
        exp_q.push_back(0);
        tick();
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (GRANT_VALID !== 1'b1 || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL basic_first: valid=%b grant=%b enc=%0d, want grant=%b enc=%0d",
                     GRANT_VALID, GRANT, GRANT_ENC, oh, e);
        end
        XFER_DONE = 1'b1;
        exp_q.push_back(2);
        tick();
        XFER_DONE = 1'b0;
        n_cmp++;
        if (GRANT_VALID !== 1'b0 || GRANT !== '0) begin
            n_bad++;
            $display("FAIL basic_idle: valid=%b grant=%b, want 0/0", GRANT_VALID, GRANT);
        end
        wait_valid(1, ok);
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL basic_second: ok=%0d grant=%b enc=%0d, want grant=%b enc=%0d",
                     ok, GRANT, GRANT_ENC, oh, e);
        end
        XFER_DONE = 1'b1;
        tick();
        XFER_DONE = 1'b0;
        REQ_QUAL  = '0;
    endtask

    task automatic test_rotation();
        bit           ok;
        int           e;
        logic [N-1:0] oh;
        do_reset();
        REQ_QUAL = 8'hFF;
        for (int k = 0; k <= N; k++) begin
            exp_q.push_back(k % N);
        end
        for (int k = 0; k <= N; k++) begin
            wait_valid(4, ok);
            e  = exp_q.pop_front();
            oh = N'(1) << e;
            n_cmp++;
            if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
                n_bad++;
                $display("FAIL rotation_%0d: ok=%0d grant=%b enc=%0d, want grant=%b enc=%0d",
                         k, ok, GRANT, GRANT_ENC, oh, e);
            end
            tick();
            tick();
            XFER_DONE = 1'b1;
            tick();
            XFER_DONE = 1'b0;
            n_cmp++;
            if (GRANT_VALID !== 1'b0) begin
                n_bad++;
                $display("FAIL rotation_idle_%0d: valid=%b, want 0", k, GRANT_VALID);
            end
        end
        REQ_QUAL = '0;
        tick();
    endtask

    task automatic test_hold();
        bit           ok;
        int           e;
        logic [N-1:0] oh;
        do_reset();
        REQ_QUAL = 8'h10;
        exp_q.push_back(4);
        wait_valid(4, ok);
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL hold_first: ok=%0d grant=%b enc=%0d, want grant=%b enc=%0d",
                     ok, GRANT, GRANT_ENC, oh, e);
        end
        REQ_QUAL = 8'h00;
        tick();
        REQ_QUAL = 8'h02;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (GRANT !== 8'h10 || GRANT_VALID !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_cycle_%0d: grant=%b valid=%b, want 00010000/1",
                         c, GRANT, GRANT_VALID);
            end
        end
        XFER_DONE = 1'b1;
        exp_q.push_back(1);
        tick();
        XFER_DONE = 1'b0;
        n_cmp++;
        if (GRANT_VALID !== 1'b0 || GRANT !== '0) begin
            n_bad++;
            $display("FAIL hold_release: valid=%b grant=%b, want 0/0", GRANT_VALID, GRANT);
        end
        wait_valid(2, ok);
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL hold_next: ok=%0d grant=%b enc=%0d, want grant=%b enc=%0d",
                     ok, GRANT, GRANT_ENC, oh, e);
        end
        XFER_DONE = 1'b1;
        tick();
        XFER_DONE = 1'b0;
        REQ_QUAL  = '0;
    endtask

    task automatic test_reset_mid_grant();
        bit           ok;
        int           e;
        logic [N-1:0] oh;
        do_reset();
        REQ_QUAL = 8'h40;
        exp_q.push_back(6);
        exp_q.push_back(6);
        for (int k = 0; k < 2; k++) begin
            wait_valid(4, ok);
            e  = exp_q.pop_front();
            oh = N'(1) << e;
            n_cmp++;
            if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
                n_bad++;
                $display("FAIL rstmid_grant_%0d: ok=%0d grant=%b enc=%0d, want enc=%0d",
                         k, ok, GRANT, GRANT_ENC, e);
            end
            if (k == 0) begin
                XFER_DONE = 1'b1;
                tick();
                XFER_DONE = 1'b0;
            end
        end
        // Pointer is now 7; after reset it must restart at 0.
        ARESET   = 1'b1;
        REQ_QUAL = 8'h81;
        tick();
        n_cmp++;
        if (GRANT !== '0 || GRANT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_drop: grant=%b valid=%b, want 0/0", GRANT, GRANT_VALID);
        end
        ARESET = 1'b0;
        exp_q.push_back(0);
        wait_valid(2, ok);
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL rstmid_ptr: ok=%0d grant=%b enc=%0d, want enc=%0d",
                     ok, GRANT, GRANT_ENC, e);
        end
        XFER_DONE = 1'b1;
        tick();
        XFER_DONE = 1'b0;
        REQ_QUAL  = '0;
    endtask

    task automatic test_xfer_in_idle();
        bit           ok;
        int           e;
        logic [N-1:0] oh;
        do_reset();
        XFER_DONE = 1'b1;
        tick();
        tick();
        XFER_DONE = 1'b0;
        n_cmp++;
        if (GRANT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_xfer_valid: got %b, want 0", GRANT_VALID);
        end
        REQ_QUAL = 8'h81;
        exp_q.push_back(0);
        wait_valid(2, ok);
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL idle_xfer_ptr: ok=%0d grant=%b enc=%0d, want enc=%0d",
                     ok, GRANT, GRANT_ENC, e);
        end
        XFER_DONE = 1'b1;
        tick();
        XFER_DONE = 1'b0;
        REQ_QUAL  = '0;
    endtask

    task automatic test_timeout();
        bit           ok;
        int           e;
        int           held;
        int           terr_early;
        logic [N-1:0] oh;
        do_reset();
        REQ_QUAL = 8'h08;
        exp_q.push_back(3);
        wait_valid(4, ok);
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        n_cmp++;
        if (!ok || GRANT !== oh || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL timeout_grant: ok=%0d grant=%b enc=%0d, want enc=%0d",
                     ok, GRANT, GRANT_ENC, e);
        end
`ifdef CAXI4INTERCONNECT_ARB_TIMEOUT_EN
        held       = 1;
        terr_early = 0;
        while (GRANT_VALID === 1'b1 && held < 40) begin
            if (TIMEOUT_ERR !== 1'b0) terr_early++;
            tick();
            if (GRANT_VALID === 1'b1) held++;
        end
        n_cmp++;
        if (held != TO || GRANT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_release: held %0d cycles valid=%b, want %0d cycles then 0",
                     held, GRANT_VALID, TO);
        end
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b1 || terr_early != 0) begin
            n_bad++;
            $display("FAIL timeout_pulse: terr=%b early=%0d, want 1 and 0 early",
                     TIMEOUT_ERR, terr_early);
        end
        REQ_QUAL = '0;
        tick();
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_once: terr=%b, want 0", TIMEOUT_ERR);
        end
        REQ_QUAL = 8'h08;
        exp_q.push_back(3);
        wait_valid(4, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || GRANT_ENC !== W'(e)) begin
            n_bad++;
            $display("FAIL timeout_regrant: ok=%0d enc=%0d, want %0d", ok, GRANT_ENC, e);
        end
        for (int c = 1; c < TO; c++) tick();
        XFER_DONE = 1'b1;
        tick();
        XFER_DONE = 1'b0;
        n_cmp++;
        if (TIMEOUT_ERR !== 1'b0 || GRANT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_xfer_wins: terr=%b valid=%b, want 0/0",
                     TIMEOUT_ERR, GRANT_VALID);
        end
`else
        held       = 1;
        terr_early = 0;
        for (int c = 0; c < 3 * TO; c++) begin
            tick();
            if (GRANT_VALID === 1'b1) held++;
            if (TIMEOUT_ERR !== 1'b0) terr_early++;
        end
        n_cmp++;
        if (held != 3 * TO + 1 || terr_early != 0) begin
            n_bad++;
            $display("FAIL no_timeout_hold: held %0d terr_cycles %0d, want %0d and 0",
                     held, terr_early, 3 * TO + 1);
        end
        XFER_DONE = 1'b1;
        tick();
        XFER_DONE = 1'b0;
        n_cmp++;
        if (GRANT_VALID !== 1'b0) begin
            n_bad++;
            $display("FAIL no_timeout_release: valid=%b, want 0", GRANT_VALID);
        end
`endif
        REQ_QUAL = '0;
        tick();
    endtask

    initial begin
        ARESET    = 1'b1;
        REQ_QUAL  = '0;
        XFER_DONE = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_hold();
        test_reset_mid_grant();
        test_xfer_in_idle();
        test_timeout();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
